// File: rtl/uart_pkg.sv
// Shared UART definitions: the frame-level state encoding used by both
// the transmitter and the receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START_BIT = 2'd1,
    DATA_BITS = 2'd2,
    STOP_BIT  = 2'd3
  } state_t;

endpackage : uart_pkg

// File: rtl/wbit_fifo.sv
// Synchronous FIFO with show-ahead read data: rdata always presents the head
// entry while empty is low. Writes when full and reads when empty are ignored.
module wbit_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  logic w_push;
  logic w_pop;

  assign full   = (r_count == CW'(DEPTH));
  assign empty  = (r_count == '0);
  assign w_push = wr_en && !full;
  assign w_pop  = rd_en && !empty;
  assign rdata  = r_mem[r_rd_ptr];

  // Pointers wrap explicitly so non-power-of-two depths work.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= (r_wr_ptr == AW'(DEPTH - 1)) ? '0 : r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == AW'(DEPTH - 1)) ? '0 : r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wdata;
    end
  end

endmodule : wbit_fifo

// File: rtl/uart_tx.sv
// UART transmitter: FIFO-buffered, 1 start / DATA_WIDTH data (LSB first) /
// 1 stop bit, each bit held for baud_div_i+1 clocks. state_o is for debug.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [15:0]           baud_div_i,
  input  logic                  tx_we_i,
  input  logic                  tx_en_i,
  input  logic [DATA_WIDTH-1:0] din_i,
  output logic                  tx_bit_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  busy_o,
  output state_t                state_o
);

  localparam int CW = $clog2(DATA_WIDTH + 1);

  state_t                r_state;
  logic [15:0]           r_baud_cnt;
  logic [CW-1:0]         r_bit_cnt;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_tx_bit;

  state_t                w_state_next;
  logic [CW-1:0]         w_bit_cnt_next;
  logic [DATA_WIDTH-1:0] w_shift_next;
  logic                  w_tx_bit_next;
  logic                  w_pop;
  logic                  w_end_tick;
  logic [DATA_WIDTH-1:0] w_fifo_rdata;
  logic                  w_fifo_empty;
  logic                  w_fifo_full;

  wbit_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .wr_en (tx_we_i),
    .wdata (din_i),
    .rd_en (w_pop),
    .rdata (w_fifo_rdata),
    .full  (w_fifo_full),
    .empty (w_fifo_empty)
  );

  assign w_end_tick = (r_baud_cnt == baud_div_i);

  always_comb begin
    w_state_next   = r_state;
    w_bit_cnt_next = r_bit_cnt;
    w_shift_next   = r_shift;
    w_pop          = 1'b0;
    case (r_state)
      IDLE: begin
        if (tx_en_i && !w_fifo_empty) begin
          w_pop        = 1'b1;
          w_shift_next = w_fifo_rdata;
          w_state_next = START_BIT;
        end
      end
      START_BIT: begin
        if (w_end_tick) begin
          w_state_next   = DATA_BITS;
          w_bit_cnt_next = '0;
        end
      end
      DATA_BITS: begin
        if (w_end_tick) begin
          w_shift_next = r_shift >> 1;
          if (r_bit_cnt == CW'(DATA_WIDTH - 1)) begin
            w_state_next = STOP_BIT;
          end else begin
            w_bit_cnt_next = r_bit_cnt + CW'(1);
          end
        end
      end
      STOP_BIT: begin
        if (w_end_tick) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase

    // The line register follows the state being entered, so the start bit
    // appears exactly one cycle after the pop.
    case (w_state_next)
      START_BIT: w_tx_bit_next = 1'b0;
      DATA_BITS: w_tx_bit_next = w_shift_next[0];
      default:   w_tx_bit_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= IDLE;
      r_baud_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_tx_bit   <= 1'b1;
    end else begin
      r_state    <= w_state_next;
      r_bit_cnt  <= w_bit_cnt_next;
      r_shift    <= w_shift_next;
      r_tx_bit   <= w_tx_bit_next;
      r_baud_cnt <= (r_state == IDLE || w_end_tick) ? '0 : r_baud_cnt + 16'd1;
    end
  end

  assign tx_bit_o = r_tx_bit;
  assign full_o   = w_fifo_full;
  assign empty_o  = w_fifo_empty;
  assign busy_o   = (r_state != IDLE);
  assign state_o  = r_state;

endmodule : uart_tx

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: hand-computed line patterns checked cycle by cycle.
module tb_uart_tx;
  import uart_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [15:0] baud_div_i = 16'd9;
  logic        tx_we_i = 1'b0;
  logic        tx_en_i = 1'b0;
  logic [7:0]  din_i = 8'h00;
  logic        tx_bit_o;
  logic        full_o;
  logic        empty_o;
  logic        busy_o;
  state_t      state_o;

  int n_checks = 0;
  int n_pass   = 0;

  uart_tx #(.DATA_WIDTH(8), .FIFO_DEPTH(16)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .baud_div_i (baud_div_i),
    .tx_we_i    (tx_we_i),
    .tx_en_i    (tx_en_i),
    .din_i      (din_i),
    .tx_bit_o   (tx_bit_o),
    .full_o     (full_o),
    .empty_o    (empty_o),
    .busy_o     (busy_o),
    .state_o    (state_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic write_byte(input logic [7:0] d);
    tx_we_i = 1'b1;
    din_i   = d;
    @(negedge clk_i);
    tx_we_i = 1'b0;
  endtask

  // Called on the first cycle of the start bit; pat[i] is the i-th line bit.
  // Returns on the first cycle after the stop bit's baud_div_i+1 cycles.
  task automatic check_frame(input string tag, input logic [9:0] pat, input int baud);
    chk({tag, " busy"}, busy_o, 1'b1);
    for (int i = 0; i < 10; i++) begin
      for (int c = 0; c <= baud; c++) begin
        chk($sformatf("%s bit%0d cyc%0d", tag, i, c), tx_bit_o, pat[i]);
        @(negedge clk_i);
      end
    end
  endtask

  initial begin
    // Reset
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    chk("rst tx", tx_bit_o, 1'b1);
    chk("rst busy", busy_o, 1'b0);
    chk("rst empty", empty_o, 1'b1);
    chk("rst full", full_o, 1'b0);
    chk("rst state", state_o, IDLE);

    // Single frame 0xA5, divisor 9
    baud_div_i = 16'd9;
    tx_en_i    = 1'b1;
    write_byte(8'hA5);
    chk("a5 pre-launch tx", tx_bit_o, 1'b1);
    @(negedge clk_i);
    check_frame("a5", 10'b1101001010, 9);
    chk("a5 busy after", busy_o, 1'b0);
    chk("a5 tx after", tx_bit_o, 1'b1);

    // Back-to-back 0x00 then 0xFF, divisor 3 (push and pop in the same cycle)
    baud_div_i = 16'd3;
    write_byte(8'h00);
    write_byte(8'hFF);
    check_frame("b2b00", 10'b1000000000, 3);
    chk("b2b extra stop", tx_bit_o, 1'b1);
    chk("b2b empty before pop", empty_o, 1'b0);
    @(negedge clk_i);
    chk("b2b empty after pop", empty_o, 1'b1);
    check_frame("b2bff", 10'b1111111110, 3);
    chk("b2b busy after", busy_o, 1'b0);

    // Overflow: 17 writes with transmit disabled
    tx_en_i    = 1'b0;
    baud_div_i = 16'd1;
    for (int k = 1; k <= 16; k++) write_byte(k[7:0]);
    chk("ovf full after 16", full_o, 1'b1);
    write_byte(8'h11);
    chk("ovf full after 17", full_o, 1'b1);
    chk("ovf idle tx", tx_bit_o, 1'b1);
    tx_en_i = 1'b1;
    @(negedge clk_i);
    chk("ovf full after pop", full_o, 1'b0);
    for (int k = 1; k <= 16; k++) begin
      check_frame($sformatf("ovf%0d", k), {1'b1, k[7:0], 1'b0}, 1);
      chk($sformatf("ovf%0d gap", k), tx_bit_o, 1'b1);
      if (k < 16) @(negedge clk_i);
    end
    chk("ovf empty end", empty_o, 1'b1);
    chk("ovf busy end", busy_o, 1'b0);
    repeat (20) @(negedge clk_i);
    chk("ovf 0x11 dropped tx", tx_bit_o, 1'b1);
    chk("ovf 0x11 dropped busy", busy_o, 1'b0);

    // Enable gating
    tx_en_i    = 1'b0;
    baud_div_i = 16'd2;
    write_byte(8'h3C);
    for (int c = 0; c < 100; c++) begin
      chk($sformatf("gate tx cyc%0d", c), tx_bit_o, 1'b1);
      chk($sformatf("gate empty cyc%0d", c), empty_o, 1'b0);
      @(negedge clk_i);
    end
    tx_en_i = 1'b1;
    @(negedge clk_i);
    check_frame("gate3c", 10'b1001111000, 2);
    chk("gate busy after", busy_o, 1'b0);

    // Reset mid-frame with a byte still queued
    baud_div_i = 16'd4;
    write_byte(8'hC3);
    write_byte(8'h77);
    repeat (12) @(negedge clk_i);
    chk("midrst in data", state_o, DATA_BITS);
    chk("midrst queued", empty_o, 1'b0);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    chk("midrst tx", tx_bit_o, 1'b1);
    chk("midrst busy", busy_o, 1'b0);
    chk("midrst empty", empty_o, 1'b1);
    chk("midrst state", state_o, IDLE);
    write_byte(8'h5A);
    @(negedge clk_i);
    check_frame("post5a", 10'b1010110100, 4);
    chk("post5a busy after", busy_o, 1'b0);

    // Minimum divisor
    baud_div_i = 16'd0;
    write_byte(8'h81);
    @(negedge clk_i);
    check_frame("min81", 10'b1100000010, 0);
    chk("min81 busy after", busy_o, 1'b0);
    chk("min81 tx after", tx_bit_o, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_uart_tx

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: number of data bits per frame.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16: transmit FIFO entries.
REQ-003 SHALL have port clk_i, input, 1: the single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst_i, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port baud_div_i, input, 16: bit period minus one, in clk_i cycles.
REQ-006 SHALL have port tx_we_i, input, 1: push din_i into the FIFO.
REQ-007 SHALL have port tx_en_i, input, 1: transmit enable.
REQ-008 SHALL have port din_i, input, DATA_WIDTH: write data.
REQ-009 SHALL have port tx_bit_o, output, 1: serial line, registered, idle high.
REQ-010 SHALL have port full_o, output, 1: FIFO full.
REQ-011 SHALL have port empty_o, output, 1: FIFO empty.
REQ-012 SHALL have port busy_o, output, 1: high whenever the state is not IDLE.

Function
REQ-013 SHALL use frame format: 1 start bit (0), DATA_WIDTH data bits LSB first, 1 stop bit (1), no parity.
REQ-014 SHALL use FSM states IDLE, START_BIT, DATA_BITS and STOP_BIT.
REQ-015 SHALL hold each non-IDLE bit for exactly baud_div_i+1 cycles: baud counter 0..baud_div_i, end_tick when counter == baud_div_i, counter cleared in IDLE and on end_tick.
REQ-016 SHALL, in IDLE with tx_en_i=1 and empty_o=0, pop one FIFO entry, load it into the shift register and move to START_BIT in the same cycle.
REQ-017 SHALL drive tx_bit_o low from the cycle after the pop, giving one cycle of launch latency.
REQ-018 SHALL, in START_BIT, move to DATA_BITS on end_tick with bit counter = 0.
REQ-019 SHALL, in DATA_BITS, drive tx_bit_o from shift-register bit 0 and shift right on each end_tick.
REQ-020 SHALL, in DATA_BITS, move to STOP_BIT on end_tick when bit counter == DATA_WIDTH-1, and otherwise increment the counter.
REQ-021 SHALL, in STOP_BIT, drive tx_bit_o = 1 and return to IDLE on end_tick.
REQ-022 SHALL make back-to-back frames possible: IDLE re-launches on the cycle after stop end, so the stop bit lasts baud_div_i+2 cycles between consecutive frames.
REQ-023 SHALL drive tx_bit_o = 1 in IDLE.
REQ-024 SHALL treat a write while full_o=1 as a dropped write, leaving FIFO contents unchanged.
REQ-025 SHALL honour a simultaneous push and pop on a non-full FIFO, leaving the count unchanged.
REQ-026 SHALL only block new launches when tx_en_i falls mid-frame; the current frame completes.
REQ-027 SHALL treat a change of baud_div_i mid-frame as outside spec; the block only guarantees correct frames with baud_div_i held stable while busy_o=1.
REQ-028 SHALL support baud_div_i = 0, which gives a 1-cycle bit and a 10-cycle frame for DATA_WIDTH=8.

Reset
REQ-029 SHALL, on rst_i=1 at a clk_i edge, set state IDLE, baud counter 0, bit counter 0, shift register 0, tx_bit_o=1, busy_o=0, FIFO flushed (empty_o=1, full_o=0).
REQ-030 SHALL abort any frame in progress on reset, with tx_bit_o high on the cycle after reset is sampled.

Structure
REQ-031 SHALL reuse the existing wbit_fifo as its only sub-module, with its active-high rst driven directly by rst_i and rd_en driven by the pop condition.
REQ-032 SHALL rely on wbit_fifo read data being show-ahead (rdata reflects the head entry while not empty), so the shift register loads rdata in the pop cycle.
REQ-033 SHALL place the state_t enum (IDLE, START_BIT, DATA_BITS, STOP_BIT) in a shared uart_pkg, reused by uart_rx.
REQ-034 SHALL derive the counter width as $clog2(DATA_WIDTH+1) locally.

Verification
REQ-035 SHALL test a single frame: baud_div_i=9, tx_en_i=1, write 0xA5 -> tx_bit_o low 10 cycles, then 1,0,1,0,0,1,0,1 at 10 cycles each, then high 10 cycles; busy_o falls after stop.
REQ-036 SHALL test back-to-back frames: write 0x00 then 0xFF, baud_div_i=3 -> two frames separated by exactly a 5-cycle high stop, with empty_o=1 after the second pop.
REQ-037 SHALL test overflow: tx_en_i=0, write 17 bytes 0x01..0x11 -> full_o=1 after 16 writes; enabling then sends 0x01..0x10 only, with 0x11 dropped.
REQ-038 SHALL test enable gating: tx_en_i=0, write 0x3C -> tx_bit_o stays 1 and empty_o=0 for 100 cycles; raising tx_en_i launches the frame 1 cycle later.
REQ-039 SHALL test reset mid-frame: assert rst_i during DATA_BITS -> next cycle tx_bit_o=1, busy_o=0, empty_o=1; a later write of 0x5A transmits correctly.
REQ-040 SHALL test minimum divisor: baud_div_i=0, write 0x81 -> 10-cycle frame 0,1,0,0,0,0,0,0,1,1.
